// File: rtl/riscv_arith_pkg.sv
// Shared arithmetic definitions for the ALU, branch unit and pipelined adder.
package riscv_arith_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 2;
    localparam int DEF_BLOCK  = 4;

    // Result flags shared by the ALU, branch compare and writeback paths.
    typedef struct packed {
        logic co;    // raw carry out of the MSB
        logic ovf;   // signed overflow
        logic zero;  // result is all zeros
        logic neg;   // result MSB
    } arith_flags_t;

endpackage

// File: rtl/csel_segment.sv
// Combinational carry-select adder over one SEG_W-bit pipeline segment.
// The lowest BLOCK slice ripples; each higher slice precomputes both carry
// cases and picks one with the carry arriving from the slice below.
module csel_segment #(
    parameter int SEG_W = 16,
    parameter int BLOCK = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    localparam int NB = SEG_W / BLOCK;

    logic             cy;
    logic [BLOCK:0]   r0;
    logic [BLOCK:0]   r1;

    // Ripple slice 0, then carry-select the remaining slices in order.
    always_comb begin
        s  = '0;
        cy = cin;
        r0 = '0;
        r1 = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        for (int j = 1; j < NB; j++) begin
            r0 = {1'b0, a[j*BLOCK +: BLOCK]} + {1'b0, b[j*BLOCK +: BLOCK]};
            r1 = {1'b0, a[j*BLOCK +: BLOCK]} + {1'b0, b[j*BLOCK +: BLOCK]}
                 + {{BLOCK{1'b0}}, 1'b1};
            s[j*BLOCK +: BLOCK] = cy ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
            cy = cy ? r1[BLOCK] : r0[BLOCK];
        end
        cout = cy;
    end

    // Carry into the MSB recovered from the MSB sum bit; used for overflow.
    assign c_msb_in = a[SEG_W-1] ^ b[SEG_W-1] ^ s[SEG_W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage k adds bits [(k+1)*SEG_W-1 : k*SEG_W]; operand bits not yet used
// ride forward in skew registers, finished sum bits in de-skew registers.
// The whole pipe moves as one: it advances when the output slot is free or
// being consumed, and freezes completely otherwise.
module pipelined_addsub
    import riscv_arith_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int BLOCK  = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SEG_W = WIDTH / STAGES;

    if (WIDTH % (STAGES * BLOCK) != 0) begin : g_param_chk
        $fatal(1, "pipelined_addsub: WIDTH=%0d is not a multiple of STAGES*BLOCK=%0d",
               WIDTH, STAGES * BLOCK);
    end

    logic              adv;
    logic              acc;
    logic [STAGES:1]   vld_pipe;

    logic [WIDTH-1:0]  fin_s;
    logic              fin_c;
    logic              fin_cmsb;

    logic [WIDTH-1:0]  s_q;
    arith_flags_t      flg_d;
    arith_flags_t      flg_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !flush;
    assign acc       = in_valid && in_ready;
    assign out_valid = vld_pipe[STAGES];

    // Valid shift register; flush empties it regardless of backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else if (adv) begin
            for (int k = STAGES; k > 1; k--) vld_pipe[k] <= vld_pipe[k-1];
            vld_pipe[1] <= acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG_W;

        logic [WIDTH-1:LO]        opa;   // operand bits from LO upward
        logic [WIDTH-1:LO]        opb;   // already conditionally inverted
        logic                     cin;
        logic [SEG_W-1:0]         seg_s;
        logic                     seg_c;
        logic                     cmsb;
        logic [LO+SEG_W-1:0]      sum;   // every sum bit known after this stage

        if (k == 0) begin : g_in
            assign opa = a;
            assign opb = b ^ {WIDTH{sub}};
            assign cin = ci;
            assign sum = seg_s;
        end else begin : g_reg
            logic [WIDTH-1:LO] opa_q;
            logic [WIDTH-1:LO] opb_q;
            logic              cin_q;
            logic [LO-1:0]     lo_q;

            // Skew (operands), carry and de-skew (low sums) registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                    cin_q <= 1'b0;
                    lo_q  <= '0;
                end else if (adv) begin
                    opa_q <= g_stg[k-1].opa[WIDTH-1:LO];
                    opb_q <= g_stg[k-1].opb[WIDTH-1:LO];
                    cin_q <= g_stg[k-1].seg_c;
                    lo_q  <= g_stg[k-1].sum;
                end
            end

            assign opa = opa_q;
            assign opb = opb_q;
            assign cin = cin_q;
            assign sum = {seg_s, lo_q};
        end

        csel_segment #(
            .SEG_W (SEG_W),
            .BLOCK (BLOCK)
        ) u_seg (
            .a        (opa[LO +: SEG_W]),
            .b        (opb[LO +: SEG_W]),
            .cin      (cin),
            .s        (seg_s),
            .cout     (seg_c),
            .c_msb_in (cmsb)
        );

        if (k == STAGES - 1) begin : g_last
            assign fin_s    = sum;
            assign fin_c    = seg_c;
            assign fin_cmsb = cmsb;
        end else begin : g_mid
            logic cmsb_unused;
            assign cmsb_unused = cmsb;
        end
    end

    // Flags from the complete sum of the last stage.
    always_comb begin
        flg_d      = '0;
        flg_d.co   = fin_c;
        flg_d.ovf  = fin_c ^ fin_cmsb;
        flg_d.zero = (fin_s == '0);
        flg_d.neg  = fin_s[WIDTH-1];
    end

    // Output rank; frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            flg_q <= '0;
        end else if (adv) begin
            s_q   <= fin_s;
            flg_q <= flg_d;
        end
    end

    assign s    = s_q;
    assign co   = flg_q.co;
    assign ovf  = flg_q.ovf;
    assign zero = flg_q.zero;
    assign neg  = flg_q.neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 32-bit/2-stage instance for directed and
// table vectors, and a 64-bit/4-stage instance for random traffic.
module tb_pipelined_addsub;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        f2, iv2, ir2, ci2, sb2, ov2, or2, co2, vf2, z2, n2;
    logic [31:0] a2, b2, s2;
    logic        f4, iv4, ir4, ci4, sb4, ov4, or4, co4, vf4, z4, n4;
    logic [63:0] a4, b4, s4;

    int   total = 0;
    int   bad   = 0;
    res_t q2[$];
    res_t q4[$];
    res_t e2, e4, x2, x4, ra2, ra4;
    bit   done4;
    vec_t tbl[10];

    pipelined_addsub #(.WIDTH(32), .STAGES(2), .BLOCK(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(f2), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .ci(ci2), .sub(sb2), .out_valid(ov2), .out_ready(or2),
        .s(s2), .co(co2), .ovf(vf2), .zero(z2), .neg(n2));

    pipelined_addsub #(.WIDTH(64), .STAGES(4), .BLOCK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(f4), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .ci(ci4), .sub(sb4), .out_valid(ov4), .out_ready(or4),
        .s(s4), .co(co4), .ovf(vf4), .zero(z4), .neg(n4));

    // Reference: wide add, overflow from operand/result signs.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sub, input int w);
        logic [64:0] full;
        logic [63:0] mask, bb, sm;
        res_t r;
        mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        bb     = (sub ? ~b : b) & mask;
        full   = {1'b0, a & mask} + {1'b0, bb} + {64'd0, ci};
        sm     = full[63:0] & mask;
        r.s    = sm;
        r.co   = full[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
        r.zero = (sm == 64'd0);
        r.neg  = sm[w-1];
        return r;
    endfunction

    function automatic res_t mkres(input logic [31:0] s, input logic co, input logic ovf,
                                   input logic zero, input logic neg);
        res_t r;
        r.s = {32'd0, s}; r.co = co; r.ovf = ovf; r.zero = zero; r.neg = neg;
        return r;
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: pop on output handshake, drop in-flight on flush, push on accept.
    always @(negedge clk) if (rst_n) begin
        if (ov2 && or2) begin
            ra2 = mkres(s2, co2, vf2, z2, n2);
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL d2_extra: unexpected output %h, want none", ra2);
            end else begin
                x2 = q2.pop_front();
                check("d2_out", ra2, x2);
            end
        end
        if (f2) q2.delete();
        if (iv2 && ir2) q2.push_back(e2);
    end

    always @(negedge clk) if (rst_n) begin
        if (ov4 && or4) begin
            ra4.s = s4; ra4.co = co4; ra4.ovf = vf4; ra4.zero = z4; ra4.neg = n4;
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL d4_extra: unexpected output %h, want none", ra4);
            end else begin
                x4 = q4.pop_front();
                check("d4_out", ra4, x4);
            end
        end
        if (f4) q4.delete();
        if (iv4 && ir4) q4.push_back(e4);
    end

    // Present one op on the 32-bit instance and hold it until accepted.
    task automatic send2(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub, input res_t e);
        bit ok;
        ok = 1'b0;
        a2 = a; b2 = b; ci2 = ci; sb2 = sub; e2 = e; iv2 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ir2) begin ok = 1'b1; break; end
            @(posedge clk);
        end
        if (ok) @(posedge clk);
        else begin
            total++; bad++;
            $display("FAIL d2_accept: in_ready stayed %0b, want 1", ir2);
        end
        #1;
        iv2 = 1'b0;
    endtask

    task automatic send4(input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic sub);
        bit ok;
        ok = 1'b0;
        a4 = a; b4 = b; ci4 = ci; sb4 = sub; e4 = model(a, b, ci, sub, 64); iv4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (ir4) begin ok = 1'b1; break; end
            @(posedge clk);
        end
        if (ok) @(posedge clk);
        else begin
            total++; bad++;
            $display("FAIL d4_accept: in_ready stayed %0b, want 1", ir4);
        end
        #1;
        iv4 = 1'b0;
    endtask

    // Op just accepted into an empty pipe: out_valid exactly 2 cycles later.
    task automatic lat2(input string tag);
        @(negedge clk);
        check({tag, "_lat_early"}, ov2, 1'b0);
        @(negedge clk);
        check({tag, "_lat_on"}, ov2, 1'b1);
        step();
    endtask

    initial begin
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        f2 = 1'b0; iv2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sb2 = 1'b0; or2 = 1'b1;
        f4 = 1'b0; iv4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; sb4 = 1'b0; or4 = 1'b1;
        e2 = '0; e4 = '0; done4 = 1'b0;

        #12;
        check("rst_ov2", ov2, 1'b0);
        check("rst_out2", {s2, co2, vf2, z2, n2}, 36'd0);
        check("rst_out4", {ov4, s4, co4, vf4, z4, n4}, 69'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Table vectors, back to back, no backpressure.
        for (int i = 0; i < 10; i++)
            send2(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub,
                  mkres(tbl[i].s, tbl[i].co, tbl[i].ovf, tbl[i].zero, tbl[i].neg));
        repeat (4) step();
        check("tbl_drain", q2.size(), 0);

        // Backpressure: stall the first result for 3 cycles while ops queue up.
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send2(i, 32'h10, 1'b0, 1'b0, model(i, 64'h10, 1'b0, 1'b0, 32));
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    step();
                    if (ov2) begin seen = 1'b1; break; end
                end
                check("bp_seen", seen, 1'b1);
                or2 = 1'b0;
                #1 check("bp_inrdy_drop", ir2, 1'b0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_hold_s", {ov2, s2}, {1'b1, 32'h11});
                    check("bp_hold_rdy", ir2, 1'b0);
                end
                step();
                or2 = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_nogap", ov2, 1'b1);
                end
            end
        join
        repeat (4) step();
        check("bp_drain", q2.size(), 0);

        // Flush with two ops in flight and a new op offered in the same cycle.
        send2(32'd100, 32'd1, 1'b0, 1'b0, model(64'd100, 64'd1, 1'b0, 1'b0, 32));
        send2(32'd200, 32'd2, 1'b0, 1'b0, model(64'd200, 64'd2, 1'b0, 1'b0, 32));
        a2 = 32'd300; b2 = 32'd3; iv2 = 1'b1; f2 = 1'b1;
        @(negedge clk);
        check("fl_inrdy", ir2, 1'b0);
        step();
        f2 = 1'b0; iv2 = 1'b0;
        @(negedge clk);
        check("fl_empty", ov2, 1'b0);
        @(negedge clk);
        check("fl_empty2", ov2, 1'b0);
        step();
        send2(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, mkres(32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0));
        lat2("fl");

        // Asynchronous reset with two ops in flight.
        send2(32'd10, 32'd20, 1'b0, 1'b0, model(64'd10, 64'd20, 1'b0, 1'b0, 32));
        send2(32'd11, 32'd21, 1'b0, 1'b0, model(64'd11, 64'd21, 1'b0, 1'b0, 32));
        check("rs_pre", ov2, 1'b1);
        #2 rst_n = 1'b0;
        q2.delete();
        q4.delete();
        #1;
        check("rs_ov", ov2, 1'b0);
        check("rs_out", {s2, co2, vf2, z2, n2}, 36'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        send2(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, mkres(32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1));
        lat2("rs");
        repeat (3) step();
        check("d2_drain", q2.size(), 0);

        // 64-bit, 4-stage random traffic with random backpressure.
        fork
            begin
                logic [63:0] ra, rb;
                for (int n = 0; n < 1000; n++) begin
                    ra = {$urandom(), $urandom()};
                    rb = {$urandom(), $urandom()};
                    case ($urandom_range(7))
                        0: ra = {64{1'b1}};
                        1: rb = {64{1'b1}};
                        2: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                        3: rb = 64'h0000_0000_FFFF_FFFF;
                        default: ;
                    endcase
                    if ($urandom_range(3) == 0) step();
                    send4(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                done4 = 1'b1;
            end
            begin
                while (!done4) begin
                    step();
                    or4 = ($urandom_range(3) != 0);
                end
                or4 = 1'b1;
            end
        join
        for (int i = 0; i < 50 && q4.size() != 0; i++) step();
        check("d4_drain", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
